// File: rtl/reg_wb_queue_if.sv
// Bundle of all handshake, drain and forwarding signals of reg_wb_queue.
//   master : producers (ALU/load), stall source and read-address source
//   slave  : the writeback queue itself
// Ports: a_* / b_* writeback requests (valid/ready/addr/data), wb_stall,
//        wen/waddr/wdata register-file write port, raddr1/2 with
//        fwd_hit1/2 and fwd_data1/2 forwarding, count occupancy.
interface reg_wb_queue_if #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  a_valid;
  logic                  a_ready;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  wb_stall;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic                  fwd_hit1;
  logic                  fwd_hit2;
  logic [DATA_WIDTH-1:0] fwd_data1;
  logic [DATA_WIDTH-1:0] fwd_data2;
  logic [CW-1:0]         count;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, wb_stall,
           raddr1, raddr2,
    input  a_ready, b_ready, wen, waddr, wdata, fwd_hit1, fwd_hit2,
           fwd_data1, fwd_data2, count
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, wb_stall,
           raddr1, raddr2,
    output a_ready, b_ready, wen, waddr, wdata, fwd_hit1, fwd_hit2,
           fwd_data1, fwd_data2, count
  );
endinterface

// File: rtl/reg_wb_queue.sv
// Write-side front end of the 32x32 register file.
// Accepts writeback requests from the ALU (A, fixed priority) and the load
// unit (B), buffers them in an in-order circular queue and drains one entry
// per cycle into the register file write port. Also forwards the newest
// pending value for the two read addresses.
// Ports: clk, rst_n (async active-low), bus (reg_wb_queue_if.slave).
module reg_wb_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_wb_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]         head_ptr;
  logic [PW-1:0]         tail_ptr;
  logic [CW-1:0]         count_q;

  logic                  not_full;
  logic                  accept_a;
  logic                  accept_b;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [DATA_WIDTH-1:0] push_data;

  // Readiness looks only at the current occupancy, so a full queue refuses
  // a request even on the edge where it drains.
  assign not_full    = (count_q != FULL);
  assign bus.a_ready = not_full;
  assign bus.b_ready = not_full && !bus.a_valid;
  assign accept_a    = bus.a_valid && not_full;
  assign accept_b    = bus.b_valid && bus.b_ready;

  // Register 0 requests finish the handshake but never occupy an entry.
  assign push_addr = accept_a ? bus.a_addr : bus.b_addr;
  assign push_data = accept_a ? bus.a_data : bus.b_data;
  assign push      = (accept_a || accept_b) && (push_addr != '0);

  assign pop       = (count_q != '0) && !bus.wb_stall;
  assign bus.wen   = pop;
  assign bus.waddr = (count_q != '0) ? mem_addr[head_ptr] : '0;
  assign bus.wdata = (count_q != '0) ? mem_data[head_ptr] : '0;
  assign bus.count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_addr[tail_ptr] <= push_addr;
        mem_data[tail_ptr] <= push_data;
        tail_ptr           <= tail_ptr + 1'b1;
      end
      if (pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Walk valid entries oldest to youngest; a later match overrides an
  // earlier one so the youngest write wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx           = '0;
    bus.fwd_hit1  = 1'b0;
    bus.fwd_hit2  = 1'b0;
    bus.fwd_data1 = '0;
    bus.fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PW'(i);
      if (CW'(i) < count_q) begin
        if ((bus.raddr1 != '0) && (mem_addr[idx] == bus.raddr1)) begin
          bus.fwd_hit1  = 1'b1;
          bus.fwd_data1 = mem_data[idx];
        end
        if ((bus.raddr2 != '0) && (mem_addr[idx] == bus.raddr2)) begin
          bus.fwd_hit2  = 1'b1;
          bus.fwd_data2 = mem_data[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_reg_wb_queue.sv
module tb_reg_wb_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  ent_t mq[$];

  reg_wb_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_wb_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected forwarding: newest queued entry for the address, none for r0.
  task automatic model_fwd(input logic [AW-1:0] ra, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (ra != 0) begin
      foreach (mq[k]) begin
        if (mq[k].addr == ra) begin
          hit = 1'b1;
          d   = mq[k].data;
        end
      end
    end
  endtask

  // One cycle: drive at negedge, compare mid-cycle, update model at posedge.
  task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic stall, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    int n;
    logic e_ar, e_br, e_wen, h1, h2;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata, d1, d2;
    @(negedge clk);
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    bus.wb_stall = stall; bus.raddr1 = r1; bus.raddr2 = r2;
    #1;
    n       = mq.size();
    e_ar    = (n != DEPTH);
    e_br    = e_ar && !av;
    e_wen   = (n != 0) && !stall;
    e_waddr = (n != 0) ? mq[0].addr : '0;
    e_wdata = (n != 0) ? mq[0].data : '0;
    model_fwd(r1, h1, d1);
    model_fwd(r2, h2, d2);
    chk("count",     32'(bus.count),   32'(n));
    chk("a_ready",   32'(bus.a_ready), 32'(e_ar));
    chk("b_ready",   32'(bus.b_ready), 32'(e_br));
    chk("wen",       32'(bus.wen),     32'(e_wen));
    chk("waddr",     32'(bus.waddr),   32'(e_waddr));
    chk("wdata",     bus.wdata,        e_wdata);
    chk("fwd_hit1",  32'(bus.fwd_hit1), 32'(h1));
    chk("fwd_data1", bus.fwd_data1,    d1);
    chk("fwd_hit2",  32'(bus.fwd_hit2), 32'(h2));
    chk("fwd_data2", bus.fwd_data2,    d2);
    @(posedge clk);
    if (e_wen) void'(mq.pop_front());
    if (av && e_ar) begin
      if (aa != 0) mq.push_back('{addr: aa, data: ad});
    end else if (bv && e_br) begin
      if (ba != 0) mq.push_back('{addr: ba, data: bd});
    end
  endtask

  task automatic idle(input logic stall);
    step(1'b0, '0, '0, 1'b0, '0, '0, stall, '0, '0);
  endtask

  task automatic push_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic stall);
    step(1'b1, a, d, 1'b0, '0, '0, stall, a, '0);
  endtask

  initial begin
    bus.a_valid = 0; bus.a_addr = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;
    bus.wb_stall = 0; bus.raddr1 = 0; bus.raddr2 = 0;
    #12;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_wen",   32'(bus.wen),   0);
    chk("rst_waddr", 32'(bus.waddr), 0);
    chk("rst_wdata", bus.wdata,      0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ALU write, then it drains the following cycle.
    push_a(5'd3, 32'h11111111, 1'b0);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd3, '0);
    idle(1'b0);

    // A beats B; B goes the next cycle.
    step(1'b1, 5'd4, 32'hA, 1'b1, 5'd5, 32'hB, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b1, 5'd5, 32'hB, 1'b0, 5'd5, 5'd4);
    idle(1'b0);
    idle(1'b0);

    // Fill under stall, fifth refused, then drain in order.
    for (int i = 1; i <= 5; i++) push_a(AW'(i), 32'(i * 16'h101), 1'b1);
    chk("full_count", 32'(bus.count), 4);
    for (int i = 0; i < 6; i++) push_a(5'd5, 32'h505, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0);

    // Forwarding picks the youngest of two same-address entries.
    push_a(5'd7, 32'h1, 1'b1);
    push_a(5'd7, 32'h2, 1'b1);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd0);
    chk("fwd_young", bus.fwd_data1, 32'h2);
    for (int i = 0; i < 3; i++) idle(1'b0);

    // Register 0 write is handshaken and dropped.
    push_a(5'd0, 32'hDEAD, 1'b0);
    idle(1'b0);
    chk("r0_count", 32'(bus.count), 0);

    // Asynchronous reset with three entries queued.
    for (int i = 1; i <= 3; i++) push_a(AW'(i + 8), 32'(i), 1'b1);
    @(negedge clk);
    bus.a_valid = 0; bus.wb_stall = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_wen",   32'(bus.wen),   0);
    mq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1) != 0, AW'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) == 0,
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
